// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : code_lock_pkg
// Description : Shared types and constant helpers for the code lock block.
//               Holds the controller state encoding and the width helpers
//               used to size the symbol index, failure counter and timers.
// Revision    : 1.0 - initial release
// ============================================================================
package code_lock_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED  = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PROG    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  // Bits needed to index 'value' distinct items; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Bits needed to hold every count from 0 up to and including max_val.
  function automatic int cnt_width(input int max_val);
    return clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_if.sv
`default_nettype none
// ============================================================================
// Module      : code_lock_if
// Description : User-side signal bundle of the code lock.
//   master : drives x (symbol), e (enter strobe), prog, relock;
//            observes L (unlocked), alarm, prog_mode, idx (next symbol index)
//   slave  : the lock itself, the mirror image of master
// Revision    : 1.0 - initial release
// ============================================================================
interface code_lock_if #(
  parameter int W = 3,
  parameter int N = 3
);
  import code_lock_pkg::*;

  localparam int IDX_W = clog2(N);

  logic [W-1:0]     x;
  logic             e;
  logic             prog;
  logic             relock;
  logic             L;
  logic             alarm;
  logic             prog_mode;
  logic [IDX_W-1:0] idx;

  modport master (
    output x, e, prog, relock,
    input  L, alarm, prog_mode, idx
  );

  modport slave (
    input  x, e, prog, relock,
    output L, alarm, prog_mode, idx
  );

endinterface
`default_nettype wire

// File: rtl/code_lock_timer.sv
`default_nettype none
// ============================================================================
// Module      : lock_timer
// Description : Loadable down-counter that saturates at zero.
//   clk, r_n  : clock, asynchronous active-low reset (count clears to 0)
//   load      : load load_val this cycle (wins over en)
//   load_val  : value to load
//   en        : decrement by one this cycle while non-zero
//   done      : count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module lock_timer import code_lock_pkg::*; #(
  parameter int MAX_VAL = 15,
  parameter int CW      = cnt_width(MAX_VAL)
) (
  input  logic          clk,
  input  logic          r_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          done
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/code_lock.sv
`default_nettype none
// ============================================================================
// Module      : code_lock
// Description : Sequential combination lock with failed-attempt lockout,
//               in-field code reprogramming and optional auto-relock.
//   clk  : clock, rising edge
//   r_n  : asynchronous active-low reset
//   bus  : code_lock_if.slave - x/e symbol entry, prog/relock requests,
//          L/alarm/prog_mode status (registered from state), idx
// Revision    : 1.0 - initial release
// ============================================================================
module code_lock import code_lock_pkg::*; #(
  parameter int             W            = 3,
  parameter int             N            = 3,
  parameter logic [N*W-1:0] DEFAULT_CODE = 9'b101_011_101,
  parameter int             MAX_FAIL     = 3,
  parameter int             LOCKOUT_CYC  = 16,
  parameter int             UNLOCK_CYC   = 0
) (
  input  logic        clk,
  input  logic        r_n,
  code_lock_if.slave  bus
);

  localparam int IDX_W  = clog2(N);
  localparam int FAIL_W = cnt_width(MAX_FAIL);
  localparam int LO_MAX = LOCKOUT_CYC - 1;
  localparam int UL_MAX = (UNLOCK_CYC > 0) ? UNLOCK_CYC - 1 : 0;
  localparam int LO_W   = cnt_width(LO_MAX);
  localparam int UL_W   = cnt_width(UL_MAX);

  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(N - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST   = FAIL_W'(MAX_FAIL - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX    = FAIL_W'(MAX_FAIL);
  localparam logic [LO_W-1:0]   LO_LOAD     = LO_W'(LO_MAX);
  localparam logic [UL_W-1:0]   UL_LOAD     = UL_W'(UL_MAX);
  localparam bit                AUTO_RELOCK = (UNLOCK_CYC > 0);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [N*W-1:0]      code_q, code_d;
  logic [N*W-1:0]      shadow_q, shadow_d;
  logic                l_q, l_d;
  logic                alarm_q, alarm_d;
  logic                prog_mode_q, prog_mode_d;

  logic [W-1:0]        cur_sym;
  logic [N*W-1:0]      shadow_wr;
  logic                lo_load, lo_en, lo_done;
  logic                ul_load, ul_en, ul_done;

  lock_timer #(.MAX_VAL(LO_MAX)) u_lockout_timer (
    .clk      (clk),
    .r_n      (r_n),
    .load     (lo_load),
    .load_val (LO_LOAD),
    .en       (lo_en),
    .done     (lo_done)
  );

  lock_timer #(.MAX_VAL(UL_MAX)) u_relock_timer (
    .clk      (clk),
    .r_n      (r_n),
    .load     (ul_load),
    .load_val (UL_LOAD),
    .en       (ul_en),
    .done     (ul_done)
  );

  // Expected code symbol at idx, and the shadow with x written at idx
  // (the latter is also the value committed on the last PROG write).
  always_comb begin
    cur_sym   = code_q[W-1:0];
    shadow_wr = shadow_q;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_sym                = code_q[k*W +: W];
        shadow_wr[k*W +: W]    = bus.x;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    fail_d   = fail_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    lo_load  = 1'b0;
    lo_en    = 1'b0;
    ul_load  = 1'b0;
    ul_en    = 1'b0;

    case (state_q)
      ST_LOCKED: begin
        if (bus.e) begin
          if (bus.x == cur_sym) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_OPEN;
              idx_d   = '0;
              fail_d  = '0;
              ul_load = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            // Wrong symbol restarts entry; the symbol itself is not retried.
            idx_d = '0;
            if (fail_q == FAIL_LAST) begin
              state_d = ST_LOCKOUT;
              fail_d  = FAIL_MAX;
              lo_load = 1'b1;
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end
        end
      end

      ST_OPEN: begin
        if (bus.relock) begin
          state_d = ST_LOCKED;
          idx_d   = '0;
        end else if (bus.prog) begin
          state_d = ST_PROG;
          idx_d   = '0;
        end else if (AUTO_RELOCK) begin
          // Timer was loaded with UNLOCK_CYC-1 on entry, so reaching zero
          // here means UNLOCK_CYC cycles have been spent in OPEN.
          if (ul_done) begin
            state_d = ST_LOCKED;
            idx_d   = '0;
          end else begin
            ul_en = 1'b1;
          end
        end
      end

      ST_PROG: begin
        if (bus.relock) begin
          state_d  = ST_LOCKED;
          idx_d    = '0;
          shadow_d = code_q;
        end else if (bus.e) begin
          shadow_d = shadow_wr;
          if (idx_q == IDX_LAST) begin
            code_d  = shadow_wr;
            state_d = ST_OPEN;
            idx_d   = '0;
            ul_load = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        if (lo_done) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
          idx_d   = '0;
        end else begin
          lo_en = 1'b1;
        end
      end

      default: begin
        state_d = ST_LOCKED;
        idx_d   = '0;
      end
    endcase
  end

  // Status flags follow the registered state, one cycle behind it.
  always_comb begin
    l_d         = (state_q == ST_OPEN);
    alarm_d     = (state_q == ST_LOCKOUT);
    prog_mode_d = (state_q == ST_PROG);
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state_q     <= ST_LOCKED;
      idx_q       <= '0;
      fail_q      <= '0;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= DEFAULT_CODE;
      l_q         <= 1'b0;
      alarm_q     <= 1'b0;
      prog_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fail_q      <= fail_d;
      code_q      <= code_d;
      shadow_q    <= shadow_d;
      l_q         <= l_d;
      alarm_q     <= alarm_d;
      prog_mode_q <= prog_mode_d;
    end
  end

  assign bus.L         = l_q;
  assign bus.alarm     = alarm_q;
  assign bus.prog_mode = prog_mode_q;
  assign bus.idx       = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_code_lock.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_lock
// Description : Self-checking bench for code_lock. Two instances share the
//               stimulus: one without auto-relock, one with UNLOCK_CYC=8.
//               A behavioural model tracks mode, entered position, failure
//               count and remaining cycles, with status flags lagging a cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_lock;

  localparam int W           = 3;
  localparam int N           = 3;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 16;

  localparam int M_LOCKED  = 0;
  localparam int M_OPEN    = 1;
  localparam int M_PROG    = 2;
  localparam int M_LOCKOUT = 3;

  localparam int DEF_SYM [N] = '{5, 3, 5};

  logic clk = 1'b0;
  logic r_n = 1'b1;
  int   compared = 0;
  int   failed   = 0;

  code_lock_if #(.W(W), .N(N)) bus0 ();
  code_lock_if #(.W(W), .N(N)) bus1 ();

  code_lock #(.W(W), .N(N), .DEFAULT_CODE(9'b101_011_101), .MAX_FAIL(MAX_FAIL),
              .LOCKOUT_CYC(LOCKOUT_CYC), .UNLOCK_CYC(0)) dut0 (
    .clk (clk), .r_n (r_n), .bus (bus0));

  code_lock #(.W(W), .N(N), .DEFAULT_CODE(9'b101_011_101), .MAX_FAIL(MAX_FAIL),
              .LOCKOUT_CYC(LOCKOUT_CYC), .UNLOCK_CYC(8)) dut1 (
    .clk (clk), .r_n (r_n), .bus (bus1));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_mode [2];
  int m_pos  [2];
  int m_fail [2];
  int m_left [2];
  int m_code [2][N];
  int m_shad [2][N];
  bit m_L    [2];
  bit m_alarm[2];
  bit m_prog [2];

  function automatic int unl_of(int i);
    return (i == 0) ? 0 : 8;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_LOCKED; m_pos[i] = 0; m_fail[i] = 0; m_left[i] = 0;
      m_L[i] = 1'b0; m_alarm[i] = 1'b0; m_prog[i] = 1'b0;
      for (int k = 0; k < N; k++) begin
        m_code[i][k] = DEF_SYM[k];
        m_shad[i][k] = DEF_SYM[k];
      end
    end
  endtask

  task automatic model_step(int i, int xv, bit ev, bit pv, bit rv);
    int pm;
    pm = m_mode[i];
    case (m_mode[i])
      M_LOCKED: if (ev) begin
        if (xv == m_code[i][m_pos[i]]) begin
          if (m_pos[i] == N - 1) begin
            m_mode[i] = M_OPEN; m_pos[i] = 0; m_fail[i] = 0; m_left[i] = unl_of(i);
          end else m_pos[i]++;
        end else begin
          m_pos[i] = 0;
          m_fail[i]++;
          if (m_fail[i] == MAX_FAIL) begin
            m_mode[i] = M_LOCKOUT; m_left[i] = LOCKOUT_CYC;
          end
        end
      end
      M_LOCKOUT: begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_mode[i] = M_LOCKED; m_fail[i] = 0; m_pos[i] = 0;
        end
      end
      M_OPEN: begin
        if (rv) begin
          m_mode[i] = M_LOCKED; m_pos[i] = 0;
        end else if (pv) begin
          m_mode[i] = M_PROG; m_pos[i] = 0;
        end else if (unl_of(i) > 0) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_mode[i] = M_LOCKED; m_pos[i] = 0;
          end
        end
      end
      default: begin
        if (rv) begin
          m_mode[i] = M_LOCKED; m_pos[i] = 0;
        end else if (ev) begin
          m_shad[i][m_pos[i]] = xv;
          if (m_pos[i] == N - 1) begin
            for (int k = 0; k < N; k++) m_code[i][k] = m_shad[i][k];
            m_mode[i] = M_OPEN; m_pos[i] = 0; m_left[i] = unl_of(i);
          end else m_pos[i]++;
        end
      end
    endcase
    m_L[i]     = (pm == M_OPEN);
    m_alarm[i] = (pm == M_LOCKOUT);
    m_prog[i]  = (pm == M_PROG);
  endtask

  function automatic logic [4:0] obs(int i);
    if (i == 0) return {bus0.L, bus0.alarm, bus0.prog_mode, bus0.idx};
    return {bus1.L, bus1.alarm, bus1.prog_mode, bus1.idx};
  endfunction

  function automatic logic [4:0] expv(int i);
    return {m_L[i], m_alarm[i], m_prog[i], 2'(m_pos[i])};
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic tick(int xv, bit ev, bit pv, bit rv);
    bus0.x = 3'(xv); bus0.e = ev; bus0.prog = pv; bus0.relock = rv;
    bus1.x = 3'(xv); bus1.e = ev; bus1.prog = pv; bus1.relock = rv;
    @(posedge clk);
    if (r_n) begin
      model_step(0, xv, ev, pv, rv);
      model_step(1, xv, ev, pv, rv);
    end
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter3(int a, int b, int c);
    tick(a, 1'b1, 1'b0, 1'b0);
    tick(b, 1'b1, 1'b0, 1'b0);
    tick(c, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic relock_both();
    tick(0, 1'b0, 1'b0, 1'b1);
    idle(1);
  endtask

  task automatic reset_assert();
    #2;
    r_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    r_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus0.x = '0; bus0.e = 0; bus0.prog = 0; bus0.relock = 0;
    bus1.x = '0; bus1.e = 0; bus1.prog = 0; bus1.relock = 0;
    #3;
    r_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (obs(i) !== 5'b0) begin
        failed++;
        $display("FAIL reset_async[%0d]: got %b required %b", i, obs(i), 5'b0);
      end
    end
    reset_release();
    idle(1);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (obs(i) !== expv(i)) begin
        failed++;
        $display("FAIL reset_model[%0d]: got %b required %b", i, obs(i), expv(i));
      end
    end
  endtask

  task automatic test_open();
    enter3(5, 3, 5);
    compared++;
    if (bus0.L !== 1'b0 || bus0.idx !== 2'd0) begin
      failed++;
      $display("FAIL open_lag: got L=%b idx=%0d required L=0 idx=0", bus0.L, bus0.idx);
    end
    idle(1);
    compared++;
    if (bus0.L !== 1'b1 || bus0.alarm !== 1'b0) begin
      failed++;
      $display("FAIL open_L: got L=%b alarm=%b required L=1 alarm=0", bus0.L, bus0.alarm);
    end
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (obs(i) !== expv(i)) begin
        failed++;
        $display("FAIL open_model[%0d]: got %b required %b", i, obs(i), expv(i));
      end
    end
    relock_both();
  endtask

  task automatic test_wrong_symbol();
    tick(5, 1'b1, 1'b0, 1'b0);
    compared++;
    if (bus0.idx !== 2'd1) begin
      failed++;
      $display("FAIL wrong_idx1: got %0d required 1", bus0.idx);
    end
    tick(7, 1'b1, 1'b0, 1'b0);
    compared++;
    if (bus0.idx !== 2'd0) begin
      failed++;
      $display("FAIL wrong_idx0: got %0d required 0", bus0.idx);
    end
    enter3(5, 3, 5);
    idle(1);
    compared++;
    if (bus0.L !== 1'b1) begin
      failed++;
      $display("FAIL wrong_reopen: got L=%b required 1", bus0.L);
    end
    relock_both();
  endtask

  task automatic test_lockout();
    int cnt0, cnt1;
    cnt0 = 0; cnt1 = 0;
    enter3(0, 0, 0);
    for (int c = 0; c < 19; c++) begin
      if (c < 16) tick($urandom_range(0, 7), 1'b1, 1'b0, 1'b0);
      else        idle(1);
      if (bus0.alarm === 1'b1) cnt0++;
      if (bus1.alarm === 1'b1) cnt1++;
      for (int i = 0; i < 2; i++) begin
        compared++;
        if (obs(i) !== expv(i)) begin
          failed++;
          $display("FAIL lockout_model[%0d] cyc %0d: got %b required %b", i, c, obs(i), expv(i));
        end
      end
    end
    compared++;
    if (cnt0 !== 16 || cnt1 !== 16) begin
      failed++;
      $display("FAIL lockout_len: got %0d/%0d required 16/16", cnt0, cnt1);
    end
    enter3(5, 3, 5);
    idle(1);
    compared++;
    if (bus0.L !== 1'b1) begin
      failed++;
      $display("FAIL lockout_reopen: got L=%b required 1", bus0.L);
    end
    relock_both();
  endtask

  task automatic test_reprogram();
    enter3(5, 3, 5);
    tick(0, 1'b0, 1'b1, 1'b0);
    tick(2, 1'b1, 1'b0, 1'b0);
    compared++;
    if (bus0.prog_mode !== 1'b1) begin
      failed++;
      $display("FAIL prog_mode: got %b required 1", bus0.prog_mode);
    end
    tick(2, 1'b1, 1'b0, 1'b0);
    tick(7, 1'b1, 1'b0, 1'b0);
    idle(1);
    compared++;
    if (bus0.L !== 1'b1 || bus0.prog_mode !== 1'b0) begin
      failed++;
      $display("FAIL prog_done: got L=%b prog_mode=%b required 1/0", bus0.L, bus0.prog_mode);
    end
    relock_both();
    enter3(5, 3, 5);
    idle(1);
    compared++;
    if (bus0.L !== 1'b0) begin
      failed++;
      $display("FAIL old_code_rejected: got L=%b required 0", bus0.L);
    end
    idle(18);
    enter3(2, 2, 7);
    idle(1);
    compared++;
    if (bus0.L !== 1'b1 || bus1.L !== 1'b1) begin
      failed++;
      $display("FAIL new_code_opens: got L=%b/%b required 1/1", bus0.L, bus1.L);
    end
  endtask

  task automatic test_prog_abort();
    tick(0, 1'b0, 1'b1, 1'b0);
    tick(1, 1'b1, 1'b0, 1'b0);
    tick(4, 1'b1, 1'b0, 1'b0);
    tick(6, 1'b1, 1'b0, 1'b1);
    idle(1);
    compared++;
    if (bus0.L !== 1'b0 || bus0.prog_mode !== 1'b0 || bus0.idx !== 2'd0) begin
      failed++;
      $display("FAIL abort_state: got L=%b prog_mode=%b idx=%0d required 0/0/0",
               bus0.L, bus0.prog_mode, bus0.idx);
    end
    enter3(2, 2, 7);
    idle(1);
    compared++;
    if (bus0.L !== 1'b1 || bus1.L !== 1'b1) begin
      failed++;
      $display("FAIL abort_old_code: got L=%b/%b required 1/1", bus0.L, bus1.L);
    end
    relock_both();
  endtask

  task automatic test_reset_mid_lockout();
    enter3(0, 0, 0);
    idle(3);
    compared++;
    if (bus0.alarm !== 1'b1) begin
      failed++;
      $display("FAIL pre_reset_alarm: got %b required 1", bus0.alarm);
    end
    reset_assert();
    compared++;
    if (bus0.alarm !== 1'b0 || bus1.alarm !== 1'b0) begin
      failed++;
      $display("FAIL reset_alarm_drop: got %b/%b required 0/0", bus0.alarm, bus1.alarm);
    end
    reset_release();
    enter3(5, 3, 5);
    idle(1);
    compared++;
    if (bus0.L !== 1'b1) begin
      failed++;
      $display("FAIL reset_default_code: got L=%b required 1", bus0.L);
    end
    relock_both();
  endtask

  task automatic test_auto_relock();
    int cnt0, cnt1;
    cnt0 = 0; cnt1 = 0;
    enter3(5, 3, 5);
    for (int c = 0; c < 12; c++) begin
      idle(1);
      if (bus0.L === 1'b1) cnt0++;
      if (bus1.L === 1'b1) cnt1++;
    end
    compared++;
    if (cnt1 !== 8) begin
      failed++;
      $display("FAIL auto_relock_len: got %0d required 8", cnt1);
    end
    compared++;
    if (cnt0 !== 12) begin
      failed++;
      $display("FAIL no_auto_relock: got %0d required 12", cnt0);
    end
    relock_both();
  endtask

  task automatic test_relock_and_prog();
    enter3(5, 3, 5);
    idle(1);
    tick(0, 1'b0, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (obs(i) !== 5'b0) begin
        failed++;
        $display("FAIL relock_wins[%0d]: got %b required %b", i, obs(i), 5'b0);
      end
    end
  endtask

  task automatic test_random();
    int xv;
    bit ev, pv, rv;
    reset_assert();
    reset_release();
    for (int c = 0; c < 600; c++) begin
      ev = 1'($urandom_range(0, 1));
      pv = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 9) == 0);
      xv = ($urandom_range(0, 2) != 0) ? m_code[0][m_pos[0]] : int'($urandom_range(0, 7));
      tick(xv, ev, pv, rv);
      for (int i = 0; i < 2; i++) begin
        compared++;
        if (obs(i) !== expv(i)) begin
          failed++;
          $display("FAIL random[%0d] cyc %0d: got %b required %b", i, c, obs(i), expv(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_wrong_symbol();
    test_lockout();
    test_reprogram();
    test_prog_abort();
    test_reset_mid_lockout();
    test_auto_relock();
    test_relock_and_prog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
